// File: rtl/cuckoo_lookup_sched.sv
// cuckoo_lookup_sched: credit-based issue of byte windows to a fixed-latency lookup engine,
// tagging each issue with its offset and collecting non-zero results in a FWFT match FIFO.
// Ports: win_* window input stream (valid/ready); eng_* engine enable, data and result inputs;
// m_* match FIFO output {suf_nc, cmp_nc, suf, cmp, offset}; pkt_done pulse when a packet's
// last tag retires; busy while a packet is being processed.
module cuckoo_lookup_sched #(
  parameter int LAT = 4,
  parameter int DEPTH = 8,
  parameter int OFFW = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              win_valid,
  output logic              win_ready,
  input  logic [159:0]      win_data,
  input  logic              win_sop,
  input  logic              win_eop,
  output logic              eng_enable,
  output logic [159:0]      eng_hash_data,
  output logic [159:0]      eng_cmp_data,
  input  logic [1:0]        eng_cmp,
  input  logic [1:0]        eng_suf,
  input  logic [1:0]        eng_cmp_nc,
  input  logic [1:0]        eng_suf_nc,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [8+OFFW-1:0] m_data,
  output logic              pkt_done,
  output logic              busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = $clog2(LAT + 1);
  localparam int TW = OFFW + 2;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state_q, state_d;
  logic [OFFW-1:0] off_q, off_cur;
  logic [TW-1:0] tag_q [LAT];
  logic [159:0] dp_q [LAT-1];
  logic [IW-1:0] inflight_q;
  logic [CW-1:0] cnt_q;
  logic [AW-1:0] wr_q, rd_q;
  logic [8+OFFW-1:0] mem [DEPTH];
  logic [31:0] used;
  logic [7:0] res;
  logic accept, tail_v, tail_eop, push, pop;
  logic [OFFW-1:0] tail_off;
  // Credits count both queued entries and tags still in the engine, so a retiring
  // result always finds room in the FIFO.
  assign used = 32'(cnt_q) + 32'(inflight_q);
  assign win_ready = !rst && state_q != DRAIN && used < 32'(DEPTH);
  assign accept = win_valid && win_ready;
  assign eng_enable = accept;
  assign off_cur = win_sop ? '0 : off_q;
  assign {tail_v, tail_off, tail_eop} = tag_q[LAT-1];
  assign eng_cmp_data = dp_q[LAT-2];
  assign res = {eng_suf_nc, eng_cmp_nc, eng_suf, eng_cmp};
  // Engine outputs are only meaningful when the tail tag is valid; otherwise they are stale.
  assign push = tail_v && |res && cnt_q != CW'(DEPTH);
  assign m_valid = cnt_q != '0;
  assign pop = m_valid && m_ready;
  assign m_data = m_valid ? mem[rd_q] : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      off_q <= '0;
      eng_hash_data <= '0;
      inflight_q <= '0;
      cnt_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < LAT; i++) tag_q[i] <= '0;
      for (int i = 0; i < LAT - 1; i++) dp_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (accept) off_q <= off_cur + 1'b1;
      if (accept) eng_hash_data <= win_data;
      inflight_q <= inflight_q + IW'(accept) - IW'(tail_v);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
      wr_q <= wr_q + AW'(push);
      rd_q <= rd_q + AW'(pop);
      tag_q[0] <= {accept, accept ? off_cur : '0, accept && win_eop};
      for (int i = 1; i < LAT; i++) tag_q[i] <= tag_q[i-1];
      dp_q[0] <= accept ? win_data : '0;
      for (int i = 1; i < LAT - 1; i++) dp_q[i] <= dp_q[i-1];
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_q] <= {res, tail_off};
  end
  always_comb begin
    state_d = state_q == DRAIN ? ((tail_v && tail_eop) ? IDLE : DRAIN)
            : accept ? (win_eop ? DRAIN : RUN) : state_q;
  end
  always_comb begin
    busy = state_q != IDLE;
    pkt_done = state_q == DRAIN && tail_v && tail_eop;
  end
endmodule

// File: tb/tb_cuckoo_lookup_sched.sv
// tb_cuckoo_lookup_sched: randomized and directed stimulus checked every cycle against a queue-based model.
module tb_cuckoo_lookup_sched;
  localparam int LAT = 4;
  localparam int DEPTH = 8;
  localparam int OFFW = 4;
  logic clk = 0, rst = 1;
  logic win_valid = 0, win_sop = 0, win_eop = 0, m_ready = 1;
  logic [159:0] win_data = '0;
  logic win_ready, eng_enable, m_valid, pkt_done, busy;
  logic [159:0] eng_hash_data, eng_cmp_data;
  logic [1:0] eng_cmp = 0, eng_suf = 0, eng_cmp_nc = 0, eng_suf_nc = 0;
  logic [8+OFFW-1:0] m_data;
  int checks = 0, errors = 0;
  int eng_mode = 0;
  bit mr_rand = 0;

  cuckoo_lookup_sched #(.LAT(LAT), .DEPTH(DEPTH), .OFFW(OFFW)) dut (
    .clk(clk), .rst(rst), .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
    .win_sop(win_sop), .win_eop(win_eop), .eng_enable(eng_enable), .eng_hash_data(eng_hash_data),
    .eng_cmp_data(eng_cmp_data), .eng_cmp(eng_cmp), .eng_suf(eng_suf), .eng_cmp_nc(eng_cmp_nc),
    .eng_suf_nc(eng_suf_nc), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .pkt_done(pkt_done), .busy(busy));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: windows in flight with their issue cycle, and the expected match FIFO contents.
  typedef struct {
    int cyc;
    logic [OFFW-1:0] off;
    logic eop;
    logic [159:0] data;
  } rec_t;
  rec_t infl[$];
  logic [8+OFFW-1:0] mq[$];
  int cyc = 0;
  logic [OFFW-1:0] m_next = 0;
  logic [159:0] m_hash = 0;
  bit m_busy = 0, m_drain = 0;

  always @(negedge clk) begin
    bit er, acc, ret, ed, push_ok;
    logic [159:0] ecmp;
    logic [7:0] res;
    logic [OFFW-1:0] off;
    if (rst) begin
      chk("rst_ready", win_ready, 0);
      chk("rst_enable", eng_enable, 0);
      chk("rst_hash", eng_hash_data, 0);
      chk("rst_cmpdata", eng_cmp_data, 0);
      chk("rst_mvalid", m_valid, 0);
      chk("rst_mdata", m_data, 0);
      chk("rst_done", pkt_done, 0);
      chk("rst_busy", busy, 0);
      infl.delete();
      mq.delete();
      m_next = 0;
      m_hash = 0;
      m_busy = 0;
      m_drain = 0;
    end else begin
      er = !m_drain && (mq.size() + infl.size() < DEPTH);
      acc = win_valid && er;
      ret = infl.size() > 0 && infl[0].cyc == cyc - LAT;
      ed = ret && infl[0].eop;
      ecmp = 0;
      foreach (infl[i]) if (infl[i].cyc == cyc - (LAT - 1)) ecmp = infl[i].data;
      res = {eng_suf_nc, eng_cmp_nc, eng_suf, eng_cmp};
      chk("win_ready", win_ready, er);
      chk("eng_enable", eng_enable, acc);
      chk("pkt_done", pkt_done, ed);
      chk("busy", busy, m_busy);
      chk("m_valid", m_valid, mq.size() != 0);
      chk("m_data", m_data, mq.size() != 0 ? mq[0] : 0);
      chk("eng_hash_data", eng_hash_data, m_hash);
      chk("eng_cmp_data", eng_cmp_data, ecmp);
      push_ok = ret && res != 0 && mq.size() < DEPTH;
      if (mq.size() != 0 && m_ready) void'(mq.pop_front());
      if (push_ok) mq.push_back({res, infl[0].off});
      if (ret) void'(infl.pop_front());
      if (ed) begin
        m_busy = 0;
        m_drain = 0;
      end
      if (acc) begin
        off = win_sop ? '0 : m_next;
        m_next = off + 1'b1;
        infl.push_back('{cyc, off, win_eop, win_data});
        m_hash = win_data;
        m_busy = 1;
        if (win_eop) m_drain = 1;
      end
    end
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (eng_mode == 0) {eng_suf_nc, eng_cmp_nc, eng_suf, eng_cmp} = 8'h00;
    else if (eng_mode == 1) {eng_suf_nc, eng_cmp_nc, eng_suf, eng_cmp} = 8'h01;
    else if (eng_mode == 2) {eng_suf_nc, eng_cmp_nc, eng_suf, eng_cmp} = 8'h03;
    else {eng_suf_nc, eng_cmp_nc, eng_suf, eng_cmp} = ($urandom % 3 == 0) ? 8'($urandom) : 8'h00;
    if (mr_rand) m_ready = $urandom % 2;
  end

  task automatic send(input logic [159:0] d, input logic s, input logic e);
    int n = 0;
    win_valid = 1;
    win_data = d;
    win_sop = s;
    win_eop = e;
    @(negedge clk);
    while (!win_ready && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (!win_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout win_ready stayed 0, expected 1 within 300 cycles");
    end
    @(posedge clk);
    #1;
    win_valid = 0;
  endtask

  task automatic idle(input int n);
    win_valid = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    chk("ready_after_rst", win_ready, 1);
    @(posedge clk);
    #1;
    // Single window packet with a case hit.
    eng_mode = 1;
    m_ready = 0;
    send(160'h41, 1, 1);
    repeat (LAT) @(negedge clk);
    chk("single_done", pkt_done, 1);
    chk("single_mvalid_pre", m_valid, 0);
    @(posedge clk);
    #1;
    chk("single_mvalid", m_valid, 1);
    chk("single_mdata", m_data, 12'h010);
    chk("single_busy", busy, 0);
    m_ready = 1;
    idle(3);
    // Ten windows, no hits.
    eng_mode = 0;
    for (int i = 0; i < 10; i++) send(160'($urandom), i == 0, i == 9);
    repeat (LAT) @(negedge clk);
    chk("nohit_done", pkt_done, 1);
    chk("nohit_mvalid", m_valid, 0);
    @(posedge clk);
    #1;
    idle(2);
    // Backpressure: hits on every window with the consumer stalled.
    eng_mode = 1;
    m_ready = 0;
    for (int i = 0; i < 8; i++) send(160'(i + 100), i == 0, 0);
    win_valid = 1;
    win_data = 160'hbeef;
    @(negedge clk);
    chk("bp_ready_low", win_ready, 0);
    repeat (6) @(negedge clk);
    chk("bp_ready_still_low", win_ready, 0);
    chk("bp_head_off", m_data[OFFW-1:0], 0);
    @(posedge clk);
    #1;
    win_valid = 0;
    m_ready = 1;
    send(160'h1, 0, 0);
    send(160'h2, 0, 1);
    idle(LAT + 4);
    // Gapped input with continuous case hits.
    eng_mode = 2;
    for (int i = 0; i < 12; i++) begin
      if ($urandom % 2) idle(1 + $urandom % 2);
      send(160'($urandom), i == 0, i == 11);
    end
    idle(LAT + 3);
    // Offset wrap over 18 windows.
    eng_mode = 1;
    for (int i = 0; i < 18; i++) send(160'(i), i == 0, i == 17);
    idle(LAT + 12);
    // Random packets, random results and consumer.
    eng_mode = 3;
    mr_rand = 1;
    for (int p = 0; p < 30; p++) begin
      int len = 1 + $urandom % 6;
      for (int i = 0; i < len; i++) begin
        if ($urandom % 3 == 0) idle(1);
        send({$urandom, $urandom, $urandom, $urandom, $urandom}, i == 0 && ($urandom % 10 != 0), i == len - 1);
      end
    end
    mr_rand = 0;
    m_ready = 1;
    idle(LAT + 12);
    // Reset with tags in flight and entries queued.
    eng_mode = 1;
    m_ready = 0;
    for (int i = 0; i < 5; i++) send(160'(i + 7), i == 0, 0);
    @(posedge clk);
    #1;
    chk("pre_rst_mvalid", m_valid, 1);
    rst = 1;
    #1;
    chk("async_mvalid", m_valid, 0);
    chk("async_busy", busy, 0);
    chk("async_ready", win_ready, 0);
    chk("async_done", pkt_done, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    m_ready = 1;
    idle(2);
    send(160'h5a, 1, 1);
    repeat (LAT) @(negedge clk);
    chk("post_rst_done", pkt_done, 1);
    @(posedge clk);
    #1;
    chk("post_rst_entry", m_data, 12'h010);
    idle(6);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
